toggle_event_receiver: RTL and testbench

//   Receiving end of a toggle-encoded event link. A remote T flip-flop flips tog_in once per event.

---
 rtl/toggle_event_receiver.sv | 115 +++++++++++
 tb/tb_toggle_event_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_receiver.sv
// Consumer side of a toggle-encoded event link: synchronises the toggle line, turns each level
// change into one event, and queues events in a saturating counter drained by valid/ready.
module toggle_event_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TOTAL_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tog_in,
  input  logic               clr,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic               evt_pulse,
  output logic [CNT_W-1:0]   pending,
  output logic [TOTAL_W-1:0] total,
  output logic               overflow
);

  localparam int unsigned InitW = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [CNT_W-1:0] PendMax = '1;

  typedef enum logic {StInit, StRun} state_e;

  state_e                 state_q, state_d;
  logic [InitW-1:0]       init_cnt_q, init_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ref_q;
  logic                   last_sync;
  logic                   run;
  logic                   det;
  logic                   dec;

  assign last_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      ref_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      // ref tracks the synchronised line every cycle: in INIT unconditionally, in RUN it only
      // differs from last_sync when an event is being detected, which is exactly when it updates.
      ref_q  <= last_sync;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // FSM next state; INIT lasts long enough for ref to settle on the synchronised level
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        if (init_cnt_q == InitW'(SYNC_STAGES)) begin
          state_d = StRun;
        end else begin
          init_cnt_d = init_cnt_q + InitW'(1);
        end
      end
      StRun: state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM outputs
  always_comb begin
    run       = (state_q == StRun);
    det       = run && (last_sync ^ ref_q);
    evt_valid = (pending != '0);
    dec       = evt_valid && evt_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pulse <= 1'b0;
      pending   <= '0;
      total     <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      evt_pulse <= 1'b0;
      pending   <= '0;
      total     <= '0;
      overflow  <= 1'b0;
    end else begin
      evt_pulse <= det;
      if (det) begin
        total <= total + TOTAL_W'(1);
      end
      // Simultaneous event and pop cancel, so a full counter does not overflow then.
      unique case ({det, dec})
        2'b10: begin
          if (pending == PendMax) begin
            overflow <= 1'b1;
          end else begin
            pending <= pending + CNT_W'(1);
          end
        end
        2'b01:   pending <= pending - CNT_W'(1);
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver; a second narrow-total instance checks counter wrap.
module tb_toggle_event_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tog_in;
  logic        clr;
  logic        evt_ready;
  logic        evt_valid;
  logic        evt_pulse;
  logic [3:0]  pending;
  logic [15:0] total;
  logic        overflow;

  logic        w_valid;
  logic        w_pulse;
  logic [3:0]  w_pending;
  logic [3:0]  w_total;
  logic        w_overflow;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  toggle_event_receiver #(
    .SYNC_STAGES(2),
    .CNT_W      (4),
    .TOTAL_W    (16)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tog_in   (tog_in),
    .clr      (clr),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_pulse(evt_pulse),
    .pending  (pending),
    .total    (total),
    .overflow (overflow)
  );

  // Narrow total so wrap-around is reachable in a short run.
  toggle_event_receiver #(
    .SYNC_STAGES(2),
    .CNT_W      (4),
    .TOTAL_W    (4)
  ) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .tog_in   (tog_in),
    .clr      (clr),
    .evt_ready(evt_ready),
    .evt_valid(w_valid),
    .evt_pulse(w_pulse),
    .pending  (w_pending),
    .total    (w_total),
    .overflow (w_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One event with sender spacing of 4 cycles; the strobe appears after the third edge.
  task automatic toggle_evt();
    tog_in = ~tog_in;
    repeat (3) tick();
    chk("evt_pulse_on_toggle", 32'(evt_pulse), 32'd1);
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    tog_in    = 1'b1;
    clr       = 1'b0;
    evt_ready = 1'b0;
    repeat (3) tick();
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_pulse", 32'(evt_pulse), 32'd0);

    // Release with tog_in high: no phantom event
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_phantom_pulse", 32'(evt_pulse), 32'd0);
    end
    chk("no_phantom_pending", 32'(pending), 32'd0);
    chk("no_phantom_total", 32'(total), 32'd0);

    // Single toggle latency: pulse after edge k+2
    tog_in = 1'b0;
    tick();
    chk("lat_pulse_k", 32'(evt_pulse), 32'd0);
    tick();
    chk("lat_pulse_k1", 32'(evt_pulse), 32'd0);
    tick();
    chk("lat_pulse_k2", 32'(evt_pulse), 32'd1);
    chk("lat_pending", 32'(pending), 32'd1);
    chk("lat_total", 32'(total), 32'd1);
    chk("lat_valid", 32'(evt_valid), 32'd1);
    tick();
    chk("lat_pulse_k3", 32'(evt_pulse), 32'd0);

    // Fill to 15
    for (int i = 0; i < 14; i++) toggle_evt();
    chk("fill_pending", 32'(pending), 32'd15);
    chk("fill_total", 32'(total), 32'd15);
    chk("fill_overflow", 32'(overflow), 32'd0);

    // Event coincides with pop while full: no change, no overflow
    tog_in = ~tog_in;
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    chk("full_pop_pulse", 32'(evt_pulse), 32'd1);
    chk("full_pop_pending", 32'(pending), 32'd15);
    chk("full_pop_overflow", 32'(overflow), 32'd0);
    chk("full_pop_total", 32'(total), 32'd16);
    chk("wrap_total_16", 32'(w_total), 32'd0);
    chk("wrap_overflow_16", 32'(w_overflow), 32'd0);

    // Drain one per cycle, then no underflow
    for (int i = 14; i >= 0; i--) begin
      tick();
      chk("drain_pending", 32'(pending), 32'(i));
    end
    repeat (3) tick();
    chk("drain_underflow", 32'(pending), 32'd0);
    chk("drain_valid", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Overflow: 15 events fill, 16th is dropped but counted in total
    for (int i = 0; i < 15; i++) toggle_evt();
    chk("ovf_pre_pending", 32'(pending), 32'd15);
    chk("ovf_pre_total", 32'(total), 32'd31);
    chk("ovf_pre_flag", 32'(overflow), 32'd0);
    toggle_evt();
    chk("ovf_pending", 32'(pending), 32'd15);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_total", 32'(total), 32'd32);
    chk("wrap_total_32", 32'(w_total), 32'd0);
    chk("wrap_overflow_32", 32'(w_overflow), 32'd1);

    // Plain clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_pending", 32'(pending), 32'd0);
    chk("clr_total", 32'(total), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);

    // Clear in the detection cycle discards the event for good
    for (int i = 0; i < 3; i++) toggle_evt();
    chk("pre_clr_pending", 32'(pending), 32'd3);
    tog_in = ~tog_in;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_det_pulse", 32'(evt_pulse), 32'd0);
    chk("clr_det_pending", 32'(pending), 32'd0);
    chk("clr_det_total", 32'(total), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("clr_no_redetect", 32'(evt_pulse), 32'd0);
    end
    chk("clr_after_pending", 32'(pending), 32'd0);
    chk("clr_after_total", 32'(total), 32'd0);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) toggle_evt();
    evt_ready = 1'b1;
    tick();
    chk("mid_drain_pending", 32'(pending), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pending", 32'(pending), 32'd0);
    chk("async_rst_total", 32'(total), 32'd0);
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    tick();
    rst_n     = 1'b1;
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_pulse", 32'(evt_pulse), 32'd0);
    end
    chk("post_rst_pending", 32'(pending), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
